// File: rtl/weighted_gen_pkg.sv
// Shared types and step defaults for the weighted_gen stream source.
package weighted_gen_pkg;

  typedef enum logic [1:0] {
    WG_IDLE = 2'd0,
    WG_RUN  = 2'd1,
    WG_DONE = 2'd2
  } wg_state_t;

  function automatic int unsigned def_val_step(input int unsigned i);
    return i + 32'd1;
  endfunction

  function automatic int unsigned def_wt_step(input int unsigned i);
    return (i * 32'd0) + 32'd1;
  endfunction

endpackage

// File: rtl/weighted_gen_lane.sv
// One channel: step registers plus value/weight accumulators; updates on the edge after advance/clear.
// Holds its state indefinitely when advance is low. Saturation with WEIGHTED_GEN_SAT_EN, wrap otherwise.
module weighted_gen_lane
  import weighted_gen_pkg::*;
#(
  parameter int DW  = 32,
  parameter int WW  = 32,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  input  logic          cfg_we,
  input  logic [DW-1:0] cfg_val_step,
  input  logic [WW-1:0] cfg_wt_step,
  output logic [DW-1:0] val,
  output logic [WW-1:0] wt,
  output logic          sat
);

  logic [DW-1:0] val_step;
  logic [WW-1:0] wt_step;
  logic [DW-1:0] val_nxt;
  logic [WW-1:0] wt_nxt;
  logic          sat_hit;

`ifdef WEIGHTED_GEN_SAT_EN
  logic [DW:0] val_sum;
  logic [WW:0] wt_sum;

  // A carry out of either sum clamps that accumulator to all-ones.
  always_comb begin
    val_sum = {1'b0, val} + {1'b0, val_step};
    wt_sum  = {1'b0, wt} + {1'b0, wt_step};
    val_nxt = val_sum[DW] ? '1 : val_sum[DW-1:0];
    wt_nxt  = wt_sum[WW] ? '1 : wt_sum[WW-1:0];
    sat_hit = val_sum[DW] | wt_sum[WW];
  end
`else
  always_comb begin
    val_nxt = val + val_step;
    wt_nxt  = wt + wt_step;
    sat_hit = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      val_step <= DW'(def_val_step(IDX));
      wt_step  <= WW'(def_wt_step(IDX));
      val      <= '0;
      wt       <= '0;
      sat      <= 1'b0;
    end else begin
      if (cfg_we) begin
        val_step <= cfg_val_step;
        wt_step  <= cfg_wt_step;
      end
      if (clear) begin
        val <= '0;
        wt  <= '0;
        sat <= 1'b0;
      end else if (advance) begin
        val <= val_nxt;
        wt  <= wt_nxt;
        sat <= sat | sat_hit;
      end
    end
  end

endmodule

// File: rtl/weighted_gen.sv
// Multi-channel value/weight frame generator; sample 0 one cycle after start, one sample/cycle.
// Output held stable under out_ready back-pressure. Optional saturation via WEIGHTED_GEN_SAT_EN.
module weighted_gen
  import weighted_gen_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DW    = 32,
  parameter int WW    = 32,
  parameter int LEN_W = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [DW-1:0]      cfg_val_step,
  input  logic [WW-1:0]      cfg_wt_step,
  input  logic               start,
  input  logic [LEN_W-1:0]   frame_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_CH*DW-1:0] out_val,
  output logic [N_CH*WW-1:0] out_wt,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [N_CH-1:0]    sat_flag
);

  wg_state_t        state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic             start_acc;
  logic             advance;
  logic             cfg_ok;

  assign start_acc = (state == WG_IDLE) && start;
  assign advance   = (state == WG_RUN) && out_ready;
  assign cfg_ok    = (state == WG_IDLE) && cfg_we;

  assign out_valid = (state == WG_RUN);
  assign out_last  = (state == WG_RUN) && (cnt == (len - LEN_W'(1)));
  assign busy      = (state != WG_IDLE);
  assign done      = (state == WG_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WG_IDLE;
      len   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        WG_IDLE: begin
          if (start) begin
            cnt <= '0;
            if (frame_len != '0) begin
              len   <= frame_len;
              state <= WG_RUN;
            end else begin
              state <= WG_DONE;
            end
          end
        end
        WG_RUN: begin
          if (out_ready) begin
            cnt <= cnt + LEN_W'(1);
            if (out_last) state <= WG_DONE;
          end
        end
        WG_DONE: state <= WG_IDLE;
        default: state <= WG_IDLE;
      endcase
    end
  end

  // Out-of-range cfg_ch simply matches no lane.
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    weighted_gen_lane #(
      .DW  (DW),
      .WW  (WW),
      .IDX (i)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .clear        (start_acc),
      .advance      (advance),
      .cfg_we       (cfg_ok && (cfg_ch == CH_W'(i))),
      .cfg_val_step (cfg_val_step),
      .cfg_wt_step  (cfg_wt_step),
      .val          (out_val[i*DW +: DW]),
      .wt           (out_wt[i*WW +: WW]),
      .sat          (sat_flag[i])
    );
  end

endmodule

// File: tb/tb_weighted_gen.sv
// Directed bench for weighted_gen with N_CH=4, DW=WW=32 and default steps.
// Checks are cycle-exact, sampled 1 time unit after each rising edge.
// Drives out_ready low for 5 cycles to exercise back-pressure hold.
module tb_weighted_gen;

    localparam int N_CH  = 4;
    localparam int DW    = 32;
    localparam int WW    = 32;
    localparam int LEN_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [1:0]         cfg_ch;
    logic [DW-1:0]      cfg_val_step;
    logic [WW-1:0]      cfg_wt_step;
    logic               start;
    logic [LEN_W-1:0]   frame_len;
    logic               out_valid;
    logic               out_ready;
    logic [N_CH*DW-1:0] out_val;
    logic [N_CH*WW-1:0] out_wt;
    logic               out_last;
    logic               busy;
    logic               done;
    logic [N_CH-1:0]    sat_flag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    weighted_gen #(
        .N_CH (N_CH), .DW (DW), .WW (WW), .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_val_step (cfg_val_step),
        .cfg_wt_step  (cfg_wt_step),
        .start        (start),
        .frame_len    (frame_len),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_val      (out_val),
        .out_wt       (out_wt),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .sat_flag     (sat_flag)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        n_err++;
        $error("FAIL timeout: bench did not finish within the wait limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        reset        = 1'b1;
        cfg_we       = 1'b0;
        cfg_ch       = 2'd0;
        cfg_val_step = '0;
        cfg_wt_step  = '0;
        start        = 1'b0;
        frame_len    = '0;
        out_ready    = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_done",  done,      1'b0);
        chk("rst_last",  out_last,  1'b0);
        chk("rst_val",   out_val,   128'h0);
        chk("rst_wt",    out_wt,    128'h0);
        chk("rst_sat",   sat_flag,  4'h0);

        // Frame of 3 with default steps, ready always high
        start = 1'b1; frame_len = 16'd3;
        step();
        start = 1'b0;
        chk("f1_s0_valid", out_valid, 1'b1);
        chk("f1_s0_busy",  busy,      1'b1);
        chk("f1_s0_val",   out_val,   128'h0);
        chk("f1_s0_wt",    out_wt,    128'h0);
        chk("f1_s0_last",  out_last,  1'b0);
        step();
        chk("f1_s1_v1",    out_val[32 +: 32], 32'd2);
        chk("f1_s1_w1",    out_wt[32 +: 32],  32'd1);
        chk("f1_s1_v3",    out_val[96 +: 32], 32'd4);
        chk("f1_s1_last",  out_last, 1'b0);
        step();
        chk("f1_s2_v1",    out_val[32 +: 32], 32'd4);
        chk("f1_s2_w1",    out_wt[32 +: 32],  32'd2);
        chk("f1_s2_v2",    out_val[64 +: 32], 32'd6);
        chk("f1_s2_last",  out_last, 1'b1);
        step();
        chk("f1_end_valid", out_valid, 1'b0);
        chk("f1_end_done",  done,      1'b1);
        chk("f1_end_busy",  busy,      1'b1);
        step();
        chk("f1_idle_done", done, 1'b0);
        chk("f1_idle_busy", busy, 1'b0);

        // Back-pressure for 5 cycles on sample 1 of a 4-sample frame
        start = 1'b1; frame_len = 16'd4;
        step();
        start = 1'b0;
        chk("bp_s0_v0", out_val[0 +: 32], 32'd0);
        step();
        chk("bp_s1_v0", out_val[0 +: 32], 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_v0",    out_val[0 +: 32], 32'd1);
            chk("bp_hold_w2",    out_wt[64 +: 32], 32'd1);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_last",  out_last,  1'b0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_s2_v0",   out_val[0 +: 32], 32'd2);
        chk("bp_s2_last", out_last, 1'b0);
        step();
        chk("bp_s3_v0",   out_val[0 +: 32], 32'd3);
        chk("bp_s3_w0",   out_wt[0 +: 32],  32'd3);
        chk("bp_s3_last", out_last, 1'b1);
        step();
        chk("bp_done", done, 1'b1);
        step();

        // Config ch2 value step to all-ones, then a 3-sample frame on the next edge
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_val_step = 32'hFFFF_FFFF; cfg_wt_step = 32'd1;
        step();
        cfg_we = 1'b0;
        start = 1'b1; frame_len = 16'd3;
        step();
        start = 1'b0;
        chk("cfg_s0_v2", out_val[64 +: 32], 32'd0);
        step();
        chk("cfg_s1_v2", out_val[64 +: 32], 32'hFFFF_FFFF);
        chk("cfg_s1_v1", out_val[32 +: 32], 32'd2);
        // Start and config attempted mid-frame must be ignored
        start = 1'b1; frame_len = 16'd7;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_val_step = 32'h100; cfg_wt_step = 32'h100;
        step();
        start = 1'b0; cfg_we = 1'b0;
`ifdef WEIGHTED_GEN_SAT_EN
        chk("cfg_s2_v2",  out_val[64 +: 32], 32'hFFFF_FFFF);
        chk("cfg_s2_sat", sat_flag, 4'b0100);
`else
        chk("cfg_s2_v2",  out_val[64 +: 32], 32'hFFFF_FFFE);
        chk("cfg_s2_sat", sat_flag, 4'b0000);
`endif
        chk("ign_s2_v0",   out_val[0 +: 32], 32'd2);
        chk("ign_s2_last", out_last, 1'b1);
        step();
        chk("cfg_done", done, 1'b1);
        step();
        chk("cfg_idle", busy, 1'b0);

        // Zero-length frame
        start = 1'b1; frame_len = 16'd0;
        step();
        start = 1'b0;
        chk("z_done",  done,      1'b1);
        chk("z_valid", out_valid, 1'b0);
        chk("z_busy",  busy,      1'b1);
        step();
        chk("z_done2",  done,      1'b0);
        chk("z_valid2", out_valid, 1'b0);
        chk("z_busy2",  busy,      1'b0);

        // ch0 step must still be the default after the ignored write
        start = 1'b1; frame_len = 16'd2;
        step();
        start = 1'b0;
        step();
        chk("ign_s1_v0",   out_val[0 +: 32], 32'd1);
        chk("ign_s1_w0",   out_wt[0 +: 32],  32'd1);
        chk("ign_s1_last", out_last, 1'b1);
        step();
        chk("ign_done", done, 1'b1);
        step();

        // Reset on sample 1 of a 10-sample frame
        start = 1'b1; frame_len = 16'd10;
        step();
        start = 1'b0;
        step();
        chk("mr_s1_v0", out_val[0 +: 32], 32'd1);
        reset = 1'b1;
        step();
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_busy",  busy,      1'b0);
        chk("mr_done",  done,      1'b0);
        chk("mr_last",  out_last,  1'b0);
        chk("mr_val",   out_val,   128'h0);
        chk("mr_wt",    out_wt,    128'h0);
        chk("mr_sat",   sat_flag,  4'h0);
        reset = 1'b0;
        step();
        chk("mr_nodone", done, 1'b0);
        start = 1'b1; frame_len = 16'd3;
        step();
        start = 1'b0;
        chk("mr_f_s0_val", out_val, 128'h0);
        step();
        chk("mr_f_s1_v2", out_val[64 +: 32], 32'd3);
        chk("mr_f_s1_v0", out_val[0 +: 32],  32'd1);
        step();
        chk("mr_f_s2_v3",   out_val[96 +: 32], 32'd8);
        chk("mr_f_s2_last", out_last, 1'b1);
        step();
        chk("mr_f_done", done, 1'b1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weighted_gen.md
# weighted_gen

Parametrised multi-channel sample/weight stream generator for the weighted-mean datapath. It supersedes the fixed four-channel free-running counter source. Each channel holds a value accumulator and a weight accumulator with run-time programmable step sizes, and emits a frame of `frame_len` samples over a valid/ready stream. Sits upstream of the weighted-mean core as its stimulus and calibration source.

## Interface
Parameters:
- `N_CH`, 4, number of channels (≥1)
- `DW`, 32, value accumulator width
- `WW`, 32, weight accumulator width
- `LEN_W`, 16, frame length counter width

Ports:
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `cfg_we` in 1: write step registers for channel `cfg_ch`
- `cfg_ch` in $clog2(N_CH) (min 1): channel index for config write
- `cfg_val_step` in DW: value step
- `cfg_wt_step` in WW: weight step
- `start` in 1: single-cycle frame start request
- `frame_len` in LEN_W: number of samples in the frame, sampled on accepted `start`
- `out_valid` out 1: sample available
- `out_ready` in 1: downstream accepts
- `out_val` out N_CH*DW: channel i at bits [i*DW +: DW]
- `out_wt` out N_CH*WW: channel i at bits [i*WW +: WW]
- `out_last` out 1: current sample is the last of the frame
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse after the frame completes
- `sat_flag` out N_CH: sticky per-channel saturation flag

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN: `start`=1 and `frame_len`≠0. Frame length is latched, all accumulators are cleared to 0, sample counter is cleared, and `sat_flag` is cleared.
- IDLE→DONE: `start`=1 and `frame_len`=0. No samples are emitted.
- RUN→DONE: handshake (`out_valid`&`out_ready`) on the sample with `out_last`=1.
- DONE→IDLE: unconditional after one cycle.
- In RUN, `out_valid`=1 continuously. Data and `out_last` are held stable until the handshake completes.
- On each handshake, for every channel i: val[i] += val_step[i] and wt[i] += wt_step[i]. The sample counter increments.
- First sample of every frame is all zeros.
- Arithmetic is unsigned. Without saturation, sums wrap modulo 2^DW or 2^WW.
- `out_last` = (sample counter == latched length − 1) while in RUN.
- `cfg_we` is honoured only in IDLE and is ignored otherwise. Out-of-range `cfg_ch` is ignored.
- `start` outside IDLE is ignored.
- Step reset defaults: val_step[i] = i+1, wt_step[i] = 1.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`, `out_last`, `busy`, `done` = 0.
  - `out_val`, `out_wt`, `sat_flag` = 0.
  - Steps return to their defaults.
- `start` accepted at edge t: `out_valid`=1 and `busy`=1 from cycle t+1, with sample 0 present.
- Throughput: one sample per cycle while `out_ready`=1. Back-pressure of any length is tolerated without data change.
- Final handshake at edge k: `out_valid`=0 and `done`=1 in cycle k+1, with `busy` still 1. IDLE is reached in cycle k+2.
- Zero-length start at edge t: `done`=1 in cycle t+1.
- A config write at edge t takes effect for a frame started at edge t+1 or later.
- Reset asserted mid-frame: at the next edge all state returns to the reset values. No `done` pulse is produced.

## Configuration
- Macro: `WEIGHTED_GEN_SAT_EN`.
- Defined: additions saturate at the all-ones value, per accumulator. A saturating add sets `sat_flag[i]`, which stays set until the next accepted `start` or `reset`.
- Undefined: additions wrap, and `sat_flag` is tied to 0.

## Structure
- Package `weighted_gen_pkg`:
  - State enum `wg_state_t`.
  - Default step functions `def_val_step(i)` and `def_wt_step(i)`.
- Sub-module `weighted_gen_lane`, instantiated N_CH times. Each lane contains:
  - Step registers.
  - Value and weight accumulators.
  - Saturation logic and the sticky flag.
  - Controls: clear, advance, config write.
- The top level holds the FSM, the sample counter, the length latch and the handshake logic.

## Test plan
- Defaults, N_CH=4, `frame_len`=3, `out_ready`=1: channel 1 values are 0, 2, 4 and weights are 0, 1, 2. `out_last` is set on the third sample. `done` is asserted 1 cycle after the third sample.
- Back-pressure: `out_ready` is held 0 for 5 cycles mid-frame. The sample is held unchanged, the count stays exact, and no sample is skipped or duplicated.
- Config: write ch2 val_step=0xFFFFFFFF with DW=32, then run `frame_len`=3. Without the macro, ch2 values are 0, 0xFFFFFFFF, 0xFFFFFFFE. With the macro, they are 0, 0xFFFFFFFF, 0xFFFFFFFF and `sat_flag[2]`=1.
- Edge cases:
  - `frame_len`=0 gives a `done` pulse with no `out_valid`.
  - `start` and `cfg_we` issued during RUN are ignored.
- Reset asserted on the second sample of a 10-sample frame: the next cycle shows all outputs at reset values and steps at defaults. A subsequent frame starts again from 0.
